// File: rtl/cpu_controller_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// The master side is the controller; the slave side is the datapath (or a bench).
interface cpu_controller_if;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       neg;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic       RegWrite;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, func3, func7, zero, neg,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, illegal, state
  );

  modport slave (
    output op, func3, func7, zero, neg,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, illegal, state
  );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback.
// Outputs are Moore per state except branch PCWrite and the execute-state ALU decode.
module cpu_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input logic               clk,
  input logic               rst,
  cpu_controller_if.master  bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StJalrLink = 4'd12,
    StLui      = 4'd13,
    StHalt     = 4'd14
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;
  localparam logic [2:0] AluXor = 3'b101;

  state_e state_q, state_d;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic       branch_taken;

  // Unknown func3 falls back to add; sub only for R-type with func7[5].
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic f7b5,
                                         input logic is_r);
    logic [2:0] ctl;
    case (f3)
      3'b000:  ctl = (is_r && f7b5) ? AluSub : AluAdd;
      3'b111:  ctl = AluAnd;
      3'b110:  ctl = AluOr;
      3'b010:  ctl = AluSlt;
      3'b100:  ctl = AluXor;
      default: ctl = AluAdd;
    endcase
    return ctl;
  endfunction

  always_comb begin
    case (bus.func3)
      3'b000:  branch_taken = bus.zero;
      3'b001:  branch_taken = ~bus.zero;
      3'b100:  branch_taken = bus.neg;
      3'b101:  branch_taken = ~bus.neg;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.op)
      OpItype, OpLoad, OpJalr: imm_src = 3'b000;
      OpStore:                 imm_src = 3'b001;
      OpBranch:                imm_src = 3'b010;
      OpJal:                   imm_src = 3'b011;
      OpLui:                   imm_src = 3'b100;
      default:                 imm_src = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = StFetch;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    result_src  = 2'd0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    alu_control = AluAdd;

    case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        pc_write   = 1'b1;
        state_d    = StDecode;
      end
      StDecode: begin
        // Precompute the PC-relative target into ALUOut.
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          default: begin
            illegal = 1'b1;
            state_d = ILLEGAL_TRAP ? StHalt : StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        state_d   = (bus.op == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        adr_src = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'd1;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = StFetch;
      end
      StExecR: begin
        alu_src_a   = 2'd2;
        alu_control = alu_dec(bus.func3, bus.func7[5], 1'b1);
        state_d     = StAluWb;
      end
      StExecI: begin
        alu_src_a   = 2'd2;
        alu_src_b   = 2'd1;
        alu_control = alu_dec(bus.func3, bus.func7[5], 1'b0);
        state_d     = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a   = 2'd2;
        alu_control = AluSub;
        pc_write    = branch_taken;
        state_d     = StFetch;
      end
      StJal: begin
        // Target was formed in DECODE; compute the link value meanwhile.
        pc_write  = 1'b1;
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        state_d   = StAluWb;
      end
      StJalr: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd1;
        result_src = 2'd2;
        pc_write   = 1'b1;
        state_d    = StJalrLink;
      end
      StJalrLink: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StLui: begin
        result_src = 2'd3;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // The register clears asynchronously, but FETCH enables must also drop while rst is held.
  assign bus.PCWrite    = pc_write & ~rst;
  assign bus.IRWrite    = ir_write & ~rst;
  assign bus.MemWrite   = mem_write & ~rst;
  assign bus.RegWrite   = reg_write & ~rst;
  assign bus.illegal    = illegal & ~rst;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_control;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: walks each instruction class cycle by cycle.
module tb_cpu_controller;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  cpu_controller_if bus ();

  cpu_controller #(
    .ILLEGAL_TRAP (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input logic n);
    bus.op    = op;
    bus.func3 = f3;
    bus.func7 = f7;
    bus.zero  = z;
    bus.neg   = n;
    #1;
  endtask

  // Starts in DECODE-bound FETCH; checks the conditional branch cycle.
  task automatic do_branch(input string tag, input logic [2:0] f3, input logic z,
                           input logic n, input logic exp_pc);
    set_instr(7'b1100011, f3, 7'd0, z, n);
    check({tag, "_imm"}, 32'(bus.ImmSrc), 32'd2);
    step();
    check({tag, "_st2"}, 32'(bus.state), 32'd1);
    step();
    check({tag, "_st3"}, 32'(bus.state), 32'd9);
    check({tag, "_pcw"}, 32'(bus.PCWrite), 32'(exp_pc));
    check({tag, "_alu"}, 32'(bus.ALUControl), 32'd1);
    step();
    check({tag, "_back"}, 32'(bus.state), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    set_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0);

    step();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_pcw", 32'(bus.PCWrite), 32'd0);
    check("rst_irw", 32'(bus.IRWrite), 32'd0);
    check("rst_memw", 32'(bus.MemWrite), 32'd0);
    check("rst_regw", 32'(bus.RegWrite), 32'd0);
    check("rst_srcb", 32'(bus.ALUSrcB), 32'd2);
    check("rst_res", 32'(bus.ResultSrc), 32'd2);
    rst = 1'b0;
    #1;

    // sub
    check("r_c1_state", 32'(bus.state), 32'd0);
    check("r_c1_pcw", 32'(bus.PCWrite), 32'd1);
    check("r_c1_irw", 32'(bus.IRWrite), 32'd1);
    check("r_c1_regw", 32'(bus.RegWrite), 32'd0);
    step();
    check("r_c2_state", 32'(bus.state), 32'd1);
    check("r_c2_srca", 32'(bus.ALUSrcA), 32'd1);
    check("r_c2_pcw", 32'(bus.PCWrite), 32'd0);
    step();
    check("r_c3_state", 32'(bus.state), 32'd6);
    check("r_c3_alu", 32'(bus.ALUControl), 32'd1);
    check("r_c3_regw", 32'(bus.RegWrite), 32'd0);
    step();
    check("r_c4_state", 32'(bus.state), 32'd8);
    check("r_c4_regw", 32'(bus.RegWrite), 32'd1);
    step();
    check("r_c5_state", 32'(bus.state), 32'd0);

    // addi with func7[5] set must still add; also xor R-type via func3 100 later
    set_instr(7'b0010011, 3'b000, 7'b0100000, 1'b0, 1'b0);
    step();
    step();
    check("i_state", 32'(bus.state), 32'd7);
    check("i_alu", 32'(bus.ALUControl), 32'd0);
    check("i_srcb", 32'(bus.ALUSrcB), 32'd1);
    step();
    step();

    set_instr(7'b0110011, 3'b100, 7'd0, 1'b0, 1'b0);
    step();
    step();
    check("xor_alu", 32'(bus.ALUControl), 32'd5);
    step();
    step();

    // lw
    set_instr(7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0);
    check("lw_c1_imm", 32'(bus.ImmSrc), 32'd0);
    step();
    check("lw_c2_imm", 32'(bus.ImmSrc), 32'd0);
    step();
    check("lw_c3_state", 32'(bus.state), 32'd2);
    step();
    check("lw_c4_state", 32'(bus.state), 32'd3);
    check("lw_c4_adr", 32'(bus.AdrSrc), 32'd1);
    step();
    check("lw_c5_state", 32'(bus.state), 32'd4);
    check("lw_c5_res", 32'(bus.ResultSrc), 32'd1);
    check("lw_c5_regw", 32'(bus.RegWrite), 32'd1);
    step();
    check("lw_back", 32'(bus.state), 32'd0);

    // sw
    set_instr(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
    check("sw_imm", 32'(bus.ImmSrc), 32'd1);
    check("sw_c1_memw", 32'(bus.MemWrite), 32'd0);
    step();
    step();
    check("sw_c3_memw", 32'(bus.MemWrite), 32'd0);
    step();
    check("sw_c4_state", 32'(bus.state), 32'd5);
    check("sw_c4_memw", 32'(bus.MemWrite), 32'd1);
    check("sw_c4_regw", 32'(bus.RegWrite), 32'd0);
    step();
    check("sw_back", 32'(bus.state), 32'd0);

    do_branch("beq", 3'b000, 1'b1, 1'b0, 1'b1);
    do_branch("bne", 3'b001, 1'b1, 1'b0, 1'b0);
    do_branch("blt", 3'b100, 1'b0, 1'b1, 1'b1);
    do_branch("bge", 3'b101, 1'b0, 1'b1, 1'b0);
    do_branch("bodd", 3'b010, 1'b1, 1'b1, 1'b0);

    // jal
    set_instr(7'b1101111, 3'b000, 7'd0, 1'b0, 1'b0);
    check("jal_imm", 32'(bus.ImmSrc), 32'd3);
    step();
    step();
    check("jal_c3_state", 32'(bus.state), 32'd10);
    check("jal_c3_pcw", 32'(bus.PCWrite), 32'd1);
    step();
    check("jal_c4_state", 32'(bus.state), 32'd8);
    check("jal_c4_regw", 32'(bus.RegWrite), 32'd1);
    step();

    // jalr
    set_instr(7'b1100111, 3'b000, 7'd0, 1'b0, 1'b0);
    step();
    step();
    check("jalr_c3_state", 32'(bus.state), 32'd11);
    check("jalr_c3_pcw", 32'(bus.PCWrite), 32'd1);
    check("jalr_c3_res", 32'(bus.ResultSrc), 32'd2);
    step();
    check("jalr_c4_state", 32'(bus.state), 32'd12);
    check("jalr_c4_regw", 32'(bus.RegWrite), 32'd1);
    check("jalr_c4_pcw", 32'(bus.PCWrite), 32'd0);
    step();

    // lui
    set_instr(7'b0110111, 3'b000, 7'd0, 1'b0, 1'b0);
    check("lui_imm", 32'(bus.ImmSrc), 32'd4);
    step();
    step();
    check("lui_c3_state", 32'(bus.state), 32'd13);
    check("lui_c3_res", 32'(bus.ResultSrc), 32'd3);
    check("lui_c3_regw", 32'(bus.RegWrite), 32'd1);
    step();
    check("lui_back", 32'(bus.state), 32'd0);

    // Reset asserted during MEMWRITE
    set_instr(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
    step();
    step();
    step();
    check("mrst_pre_memw", 32'(bus.MemWrite), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mrst_memw", 32'(bus.MemWrite), 32'd0);
    check("mrst_state", 32'(bus.state), 32'd0);
    check("mrst_pcw", 32'(bus.PCWrite), 32'd0);
    step();
    rst = 1'b0;
    #1;

    // Illegal opcode traps into HALT
    set_instr(7'b1111111, 3'b000, 7'd0, 1'b0, 1'b0);
    check("ill_c1_flag", 32'(bus.illegal), 32'd0);
    step();
    check("ill_c2_state", 32'(bus.state), 32'd1);
    check("ill_c2_flag", 32'(bus.illegal), 32'd1);
    step();
    check("ill_c3_state", 32'(bus.state), 32'd14);
    check("ill_c3_flag", 32'(bus.illegal), 32'd0);
    check("ill_c3_pcw", 32'(bus.PCWrite), 32'd0);
    check("ill_c3_irw", 32'(bus.IRWrite), 32'd0);
    step();
    step();
    check("ill_stay", 32'(bus.state), 32'd14);
    check("ill_stay_regw", 32'(bus.RegWrite), 32'd0);
    rst = 1'b1;
    #1;
    check("ill_rst", 32'(bus.state), 32'd0);
    step();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
